// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a stream of 16-bit products into one saturated
// dot-product result per packet. Packets close on in_last or after MAX_TERMS
// beats. Valid/ready handshake on input and output.
module mac_accumulator #(
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_TERMS = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_product,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SumW = ACC_W + 1;

    typedef enum logic {StAccum, StHold} state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             accept;
    logic [SumW-1:0]  sum_ext;
    logic             sat;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit_max;
    logic             close;

    // Beat arithmetic: one extra bit catches the carry that triggers saturation.
    always_comb begin
        accept  = in_valid & in_ready;
        sum_ext = {1'b0, acc_q} + SumW'(in_product);
        // Once saturated the packet stays pinned at all ones.
        sat     = ovf_q | sum_ext[ACC_W];
        acc_nxt = sat ? '1 : sum_ext[ACC_W-1:0];
        cnt_nxt = cnt_q + CNT_W'(1);
        hit_max = (cnt_nxt == CNT_W'(MAX_TERMS));
        close   = accept & (in_last | hit_max);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: close a packet into HOLD, release on output handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (close)     state_d = StHold;
            StHold:  if (out_ready) state_d = StAccum;
            default:                state_d = StAccum;
        endcase
    end

    // Handshake outputs decode registered state only; no path from out_ready.
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StHold);
    end

    // Accumulator and result registers; result fields hold while in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (close) begin
            out_sum   <= acc_nxt;
            out_count <= cnt_nxt;
            out_ovf   <= sat;
            // An explicit last wins over the term limit.
            out_trunc <= ~in_last;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
            ovf_q <= sat;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator. Three instances cover the default
// configuration, a narrow accumulator (ACC_W=17) and a short packet limit
// (MAX_TERMS=4); each has its own stimulus signals.
module tb_mac_accumulator;

    logic clk;
    logic rst;

    logic [15:0] prod  [3];
    logic        valid [3];
    logic        last  [3];
    logic        rdy   [3];
    logic [23:0] sum   [3];
    logic [7:0]  cnt   [3];
    logic        ovf   [3];
    logic        trunc [3];
    logic        ovalid[3];
    logic        ordy  [3];

    logic [16:0] sum1;
    assign sum[1] = {7'b0, sum1};

    int tests;
    int failed;

    mac_accumulator u_dflt (
        .clk(clk), .rst(rst), .in_product(prod[0]), .in_valid(valid[0]),
        .in_last(last[0]), .in_ready(rdy[0]), .out_sum(sum[0]), .out_count(cnt[0]),
        .out_ovf(ovf[0]), .out_trunc(trunc[0]), .out_valid(ovalid[0]),
        .out_ready(ordy[0])
    );

    mac_accumulator #(.ACC_W(17)) u_sat (
        .clk(clk), .rst(rst), .in_product(prod[1]), .in_valid(valid[1]),
        .in_last(last[1]), .in_ready(rdy[1]), .out_sum(sum1), .out_count(cnt[1]),
        .out_ovf(ovf[1]), .out_trunc(trunc[1]), .out_valid(ovalid[1]),
        .out_ready(ordy[1])
    );

    mac_accumulator #(.MAX_TERMS(4)) u_trunc (
        .clk(clk), .rst(rst), .in_product(prod[2]), .in_valid(valid[2]),
        .in_last(last[2]), .in_ready(rdy[2]), .out_sum(sum[2]), .out_count(cnt[2]),
        .out_ovf(ovf[2]), .out_trunc(trunc[2]), .out_valid(ovalid[2]),
        .out_ready(ordy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return #1 after the edge that accepted it.
    task automatic send_beat(input int d, input logic [15:0] p, input logic l);
        bit done;
        done     = 1'b0;
        prod[d]  = p;
        last[d]  = l;
        valid[d] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (rdy[d]) done = 1'b1;
            step();
        end
        valid[d] = 1'b0;
        last[d]  = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input int d, input string tag, input logic [31:0] s,
                                input logic [31:0] c, input logic o, input logic t);
        check({tag, "_valid"}, {31'd0, ovalid[d]}, 32'd1);
        check({tag, "_sum"},   s, sum[d]);
        check({tag, "_count"}, c, {24'd0, cnt[d]});
        check({tag, "_ovf"},   {31'd0, o}, {31'd0, ovf[d]});
        check({tag, "_trunc"}, {31'd0, t}, {31'd0, trunc[d]});
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        for (int d = 0; d < 3; d++) begin
            prod[d]  = '0;
            valid[d] = 1'b0;
            last[d]  = 1'b0;
            ordy[d]  = 1'b1;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, ovalid[0]}, 32'd0);
        check("rst_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_sum",   {8'd0, sum[0]}, 32'd0);
        check("rst_count", {24'd0, cnt[0]}, 32'd0);
        check("rst_ovf",   {31'd0, ovf[0]}, 32'd0);
        check("rst_trunc", {31'd0, trunc[0]}, 32'd0);

        // Basic: 6 + 35
        send_beat(0, 16'd6, 1'b0);
        check("basic_novalid", {31'd0, ovalid[0]}, 32'd0);
        send_beat(0, 16'd35, 1'b1);
        check_result(0, "basic", 32'd41, 32'd2, 1'b0, 1'b0);
        check("basic_busy", {31'd0, rdy[0]}, 32'd0);
        step();
        check("basic_release", {31'd0, ovalid[0]}, 32'd0);
        check("basic_ready",   {31'd0, rdy[0]}, 32'd1);

        // Single max product, then a 1 to confirm the accumulator cleared
        send_beat(0, 16'd65025, 1'b1);
        check_result(0, "single", 32'd65025, 32'd1, 1'b0, 1'b0);
        send_beat(0, 16'd1, 1'b1);
        check_result(0, "cleared", 32'd1, 32'd1, 1'b0, 1'b0);

        // Backpressure
        step();
        ordy[0] = 1'b0;
        send_beat(0, 16'd100, 1'b1);
        check_result(0, "bp", 32'd100, 32'd1, 1'b0, 1'b0);
        prod[0]  = 16'd7;
        valid[0] = 1'b1;
        last[0]  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", {31'd0, rdy[0]}, 32'd0);
            check("bp_valid", {31'd0, ovalid[0]}, 32'd1);
            check("bp_sum",   {8'd0, sum[0]}, 32'd100);
            check("bp_count", {24'd0, cnt[0]}, 32'd1);
        end
        ordy[0] = 1'b1;
        last[0] = 1'b1;
        step();
        check("bp_release", {31'd0, ovalid[0]}, 32'd0);
        check("bp_ready_after", {31'd0, rdy[0]}, 32'd1);
        step();
        valid[0] = 1'b0;
        last[0]  = 1'b0;
        check_result(0, "bp_next", 32'd7, 32'd1, 1'b0, 1'b0);

        // Saturation with ACC_W=17
        send_beat(1, 16'd65025, 1'b0);
        send_beat(1, 16'd65025, 1'b0);
        send_beat(1, 16'd65025, 1'b1);
        check_result(1, "sat", 32'd131071, 32'd3, 1'b1, 1'b0);
        send_beat(1, 16'd5, 1'b1);
        check_result(1, "sat_next", 32'd5, 32'd1, 1'b0, 1'b0);

        // Truncation with MAX_TERMS=4
        for (int i = 0; i < 4; i++) send_beat(2, 16'd1, 1'b0);
        check_result(2, "trunc", 32'd4, 32'd4, 1'b0, 1'b1);
        send_beat(2, 16'd1, 1'b0);
        check("trunc_open", {31'd0, ovalid[2]}, 32'd0);
        send_beat(2, 16'd2, 1'b1);
        check_result(2, "trunc_next", 32'd3, 32'd2, 1'b0, 1'b0);
        // in_last coinciding with the term limit is not a truncation
        for (int i = 0; i < 3; i++) send_beat(2, 16'd10, 1'b0);
        send_beat(2, 16'd10, 1'b1);
        check_result(2, "limit_last", 32'd40, 32'd4, 1'b0, 1'b0);

        // Reset mid-packet discards the partial sum
        step();
        send_beat(0, 16'd9, 1'b0);
        send_beat(0, 16'd9, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", {31'd0, ovalid[0]}, 32'd0);
        check("mrst_ready", {31'd0, rdy[0]}, 32'd1);
        send_beat(0, 16'd10, 1'b1);
        check_result(0, "mrst", 32'd10, 32'd1, 1'b0, 1'b0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
